// File: rtl/serial_bus_pkg.sv
// Shared definitions for the single-wire serial bus: slave FSM states,
// header layout and RW encoding common to master and slave.
package serial_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DECODE,
      ST_WR_DATA,
      ST_RD_FETCH,
      ST_RD_LOAD,
      ST_RD_DATA
   } slave_state_e;

   // START + ID[1:0] + RW + BURST precede the address field.
   localparam int HDR_CTRL_BITS = 5;
   localparam int HEADER_LEN    = HDR_CTRL_BITS + 12;

   // Field positions in the post-START payload, counted above the address LSBs.
   localparam int HDR_BURST_OFS = 0;
   localparam int HDR_RW_OFS    = 1;
   localparam int HDR_ID_OFS    = 2;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/slave_mem.sv
// Single-port synchronous word RAM, one-cycle read latency, write-first.
module slave_mem #(
   parameter int MEMORY_DEPTH  = 4096,
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = $clog2(MEMORY_DEPTH)
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [ADDRESS_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   output logic [DATA_WIDTH-1:0]    rdata
);

   logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
         rdata_q     <= wdata;
      end else begin
         rdata_q     <= mem_q[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/serial_slave.sv
// Serial bus responder: header deserialiser, ID match, single/burst word
// transfers against local RAM. SERIAL_SLAVE_WRAP_EN selects burst address wrap.
module serial_slave
   import serial_bus_pkg::*;
#(
   parameter logic [1:0] SLAVE_ID      = 2'b01,
   parameter int         MEMORY_DEPTH  = 4096,
   parameter int         DATA_WIDTH    = 16,
   parameter int         ADDRESS_WIDTH = $clog2(MEMORY_DEPTH)
) (
   input  logic clk,
   input  logic rst,
   input  logic control,
   input  logic wrD,
   input  logic valid,
   input  logic last,
   output logic rD,
   output logic ready
);

   localparam int PAYLOAD_LEN = ADDRESS_WIDTH + HDR_CTRL_BITS - 1;
   localparam int CNT_MAX     = (PAYLOAD_LEN > DATA_WIDTH) ? PAYLOAD_LEN : DATA_WIDTH;
   localparam int CNT_W       = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(PAYLOAD_LEN - 1);
   localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_WIDTH - 1);

   slave_state_e              state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [PAYLOAD_LEN-1:0]    hdr_q, hdr_d;
   logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
   logic                      burst_q, burst_d;
   logic                      last_seen_q, last_seen_d;
   logic                      ovf_q, ovf_d;
   logic [DATA_WIDTH-1:0]     wr_shift_q, wr_shift_d;
   logic [DATA_WIDTH-1:0]     rd_shift_q, rd_shift_d;
   logic                      ready_q, ready_d;

   logic                      mem_we;
   logic [DATA_WIDTH-1:0]     mem_wdata;
   logic [DATA_WIDTH-1:0]     mem_rdata;
   logic [ADDRESS_WIDTH-1:0]  addr_step;
   logic                      step_sat;

   logic [1:0]                hdr_id;
   logic                      hdr_rw;
   logic                      hdr_burst;
   logic [ADDRESS_WIDTH-1:0]  hdr_addr;

   assign hdr_id    = hdr_q[ADDRESS_WIDTH+HDR_ID_OFS +: 2];
   assign hdr_rw    = hdr_q[ADDRESS_WIDTH+HDR_RW_OFS];
   assign hdr_burst = hdr_q[ADDRESS_WIDTH+HDR_BURST_OFS];
   assign hdr_addr  = hdr_q[ADDRESS_WIDTH-1:0];

`ifdef SERIAL_SLAVE_WRAP_EN
   // Power-of-two depth makes the natural overflow the wrap to 0.
   assign addr_step = addr_q + 1'b1;
   assign step_sat  = 1'b0;
`else
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);
   assign step_sat  = (addr_q == ADDR_MAX);
   assign addr_step = step_sat ? addr_q : addr_q + 1'b1;
`endif

   slave_mem #(
      .MEMORY_DEPTH (MEMORY_DEPTH),
      .DATA_WIDTH   (DATA_WIDTH),
      .ADDRESS_WIDTH(ADDRESS_WIDTH)
   ) u_mem (
      .clk  (clk),
      .we   (mem_we),
      .addr (addr_q),
      .wdata(mem_wdata),
      .rdata(mem_rdata)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hdr_d       = hdr_q;
      addr_d      = addr_q;
      burst_d     = burst_q;
      last_seen_d = last_seen_q;
      ovf_d       = ovf_q;
      wr_shift_d  = wr_shift_q;
      rd_shift_d  = rd_shift_q;
      mem_we      = 1'b0;
      mem_wdata   = {wr_shift_q[DATA_WIDTH-2:0], wrD};

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (control) state_d = ST_HDR;
         end
         ST_HDR: begin
            hdr_d = {hdr_q[PAYLOAD_LEN-2:0], control};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == HDR_LAST) begin
               cnt_d   = '0;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (hdr_id == SLAVE_ID) begin
               addr_d      = hdr_addr;
               burst_d     = hdr_burst;
               last_seen_d = 1'b0;
               ovf_d       = 1'b0;
               cnt_d       = '0;
               state_d     = (hdr_rw == RW_WRITE) ? ST_WR_DATA : ST_RD_FETCH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WR_DATA: begin
            if (valid) begin
               wr_shift_d  = mem_wdata;
               cnt_d       = cnt_q + 1'b1;
               last_seen_d = last_seen_q | last;
               if (cnt_q == WORD_LAST) begin
                  // Words past a saturated end address still handshake but are dropped.
                  mem_we = ~ovf_q;
                  cnt_d  = '0;
                  if (!burst_q || last_seen_q || last) begin
                     state_d = ST_IDLE;
                  end else begin
                     addr_d      = addr_step;
                     ovf_d       = ovf_q | step_sat;
                     last_seen_d = 1'b0;
                  end
               end
            end
         end
         ST_RD_FETCH: begin
            state_d = ST_RD_LOAD;
         end
         ST_RD_LOAD: begin
            rd_shift_d = ovf_q ? '0 : mem_rdata;
            cnt_d      = '0;
            state_d    = ST_RD_DATA;
         end
         ST_RD_DATA: begin
            // Zero fill leaves rD low once the word has been fully presented.
            rd_shift_d  = {rd_shift_q[DATA_WIDTH-2:0], 1'b0};
            cnt_d       = cnt_q + 1'b1;
            last_seen_d = last_seen_q | last;
            if (cnt_q == WORD_LAST) begin
               cnt_d = '0;
               if (!burst_q || last_seen_q || last) begin
                  state_d = ST_IDLE;
               end else begin
                  addr_d      = addr_step;
                  ovf_d       = ovf_q | step_sat;
                  last_seen_d = 1'b0;
                  state_d     = ST_RD_FETCH;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ready_d = (state_d == ST_WR_DATA) || (state_d == ST_RD_DATA);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         hdr_q       <= '0;
         addr_q      <= '0;
         burst_q     <= 1'b0;
         last_seen_q <= 1'b0;
         ovf_q       <= 1'b0;
         wr_shift_q  <= '0;
         rd_shift_q  <= '0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hdr_q       <= hdr_d;
         addr_q      <= addr_d;
         burst_q     <= burst_d;
         last_seen_q <= last_seen_d;
         ovf_q       <= ovf_d;
         wr_shift_q  <= wr_shift_d;
         rd_shift_q  <= rd_shift_d;
         ready_q     <= ready_d;
      end
   end

   assign rD    = rd_shift_q[DATA_WIDTH-1];
   assign ready = ready_q;

endmodule

// File: tb/tb_serial_slave.sv
// Directed plus randomized bench for serial_slave against a word-array model
// of the memory and the bus handshake timing.
module tb_serial_slave;
   import serial_bus_pkg::*;

   localparam int DEPTH = 4096;
   localparam int DW    = 16;

   logic clk = 1'b0;
   logic rst, control, wrD, valid, last;
   logic rD, ready;

   int tests = 0;
   int fails = 0;

   logic [DW-1:0] model [DEPTH];
   bit            known [DEPTH];
   logic [DW-1:0] wbuf  [4];

   serial_slave #(
      .SLAVE_ID    (2'b01),
      .MEMORY_DEPTH(DEPTH),
      .DATA_WIDTH  (DW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .control(control),
      .wrD    (wrD),
      .valid  (valid),
      .last   (last),
      .rD     (rD),
      .ready  (ready)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Address of burst word i, or -1 when the word falls past a saturated end.
   function automatic int word_addr(input int base, input int i);
      int a;
      a = base + i;
`ifdef SERIAL_SLAVE_WRAP_EN
      return a % DEPTH;
`else
      return (a >= DEPTH) ? -1 : a;
`endif
   endfunction

   task automatic send_header(input logic [1:0] id, input logic rw, input logic burst,
                              input logic [11:0] addr);
      logic [HEADER_LEN-1:0] h;
      h = {1'b1, id, rw, burst, addr};
      for (int i = HEADER_LEN - 1; i >= 0; i--) begin
         @(negedge clk);
         control = h[i];
      end
      @(negedge clk);
      control = 1'b0;
   endtask

   task automatic do_write(input logic [1:0] id, input logic burst, input logic [11:0] addr,
                           input int n, input int gap_at, input string tag);
      logic match;
      bit   bad;
      int   k;
      int   a;
      match = (id == 2'b01);
      $display("[TB] write %s id=%0d burst=%0d addr=%0h words=%0d", tag, id, burst, addr, n);
      send_header(id, RW_WRITE, burst, addr);
      check({tag, " decode ready"}, 32'(ready), 32'(0));
      @(negedge clk);
      check({tag, " ready rise"}, 32'(ready), 32'(match));
      bad = 0;
      k   = 0;
      for (int w = 0; w < n; w++) begin
         for (int b = DW - 1; b >= 0; b--) begin
            if (k == gap_at) begin
               valid = 1'b0;
               repeat (3) begin
                  @(negedge clk);
                  if (ready !== match) bad = 1;
               end
            end
            valid = 1'b1;
            wrD   = wbuf[w][b];
            last  = burst && (w == n - 1);
            @(negedge clk);
            k++;
            if (!(w == n - 1 && b == 0) && ready !== match) bad = 1;
         end
      end
      valid = 1'b0;
      last  = 1'b0;
      wrD   = 1'b0;
      check({tag, " ready hold"}, 32'(bad), 32'(0));
      check({tag, " ready fall"}, 32'(ready), 32'(0));
      if (match) begin
         for (int w = 0; w < n; w++) begin
            a = word_addr(int'(addr), w);
            if (a >= 0) begin
               model[a] = wbuf[w];
               known[a] = 1;
            end
         end
      end
   endtask

   task automatic do_read(input logic burst, input logic [11:0] addr, input int n,
                          input string tag);
      int            gap;
      bit            nz;
      bit            drop;
      int            a;
      logic [DW-1:0] obs;
      logic [DW-1:0] exp;
      $display("[TB] read  %s burst=%0d addr=%0h words=%0d", tag, burst, addr, n);
      send_header(2'b01, RW_READ, burst, addr);
      for (int w = 0; w < n; w++) begin
         gap = 0;
         nz  = 0;
         while (!ready && gap < 10) begin
            if (rD !== 1'b0) nz = 1;
            gap++;
            @(negedge clk);
         end
         check($sformatf("%s w%0d ready gap", tag, w), 32'(gap), (w == 0) ? 32'(3) : 32'(2));
         check($sformatf("%s w%0d rD idle", tag, w), 32'(nz), 32'(0));
         obs  = '0;
         drop = 0;
         for (int b = 0; b < DW; b++) begin
            if (b == 0 && burst && w == n - 1) last = 1'b1;
            obs = {obs[DW-2:0], rD};
            if (ready !== 1'b1) drop = 1;
            @(negedge clk);
         end
         last = 1'b0;
         check($sformatf("%s w%0d ready width", tag, w), 32'(drop), 32'(0));
         a   = word_addr(int'(addr), w);
         exp = (a < 0) ? '0 : model[a];
         check($sformatf("%s w%0d data", tag, w), 32'(obs), 32'(exp));
      end
      check({tag, " end ready"}, 32'(ready), 32'(0));
      check({tag, " end rD"}, 32'(rD), 32'(0));
   endtask

   initial begin
      logic [1:0]  rid;
      logic [11:0] raddr;
      int          rn;
      logic        rburst;

      rst = 1'b1; control = 1'b0; wrD = 1'b0; valid = 1'b0; last = 1'b0;
      repeat (3) @(negedge clk);
      check("reset ready", 32'(ready), 32'(0));
      check("reset rD", 32'(rD), 32'(0));
      rst = 1'b0;
      @(negedge clk);

      wbuf[0] = 16'h800A;
      do_write(2'b01, 1'b0, 12'h000, 1, -1, "single");
      do_read(1'b0, 12'h000, 1, "single");

      wbuf[0] = 16'h000E; wbuf[1] = 16'h0011; wbuf[2] = 16'h0012;
      do_write(2'b01, 1'b1, 12'h003, 3, -1, "burst3");
      do_read(1'b1, 12'h003, 3, "burst3");

      wbuf[0] = 16'hFFFF;
      do_write(2'b10, 1'b0, 12'h000, 1, -1, "wrong_id");
      do_read(1'b0, 12'h000, 1, "after_wrong_id");

      wbuf[0] = 16'h1234;
      do_write(2'b01, 1'b0, 12'h005, 1, 8, "valid_gap");
      do_read(1'b0, 12'h005, 1, "valid_gap");

      wbuf[0] = 16'hAAAA; wbuf[1] = 16'h5555;
      do_write(2'b01, 1'b1, 12'hFFF, 2, -1, "edge");
      do_read(1'b0, 12'h000, 1, "edge_addr0");
      do_read(1'b0, 12'hFFF, 1, "edge_top");
      do_read(1'b1, 12'hFFF, 2, "edge_burst");

      // Abort a write to addr 3 after 8 bits; its old contents must survive.
      $display("[TB] write reset_abort addr=3 (8 bits then rst)");
      send_header(2'b01, RW_WRITE, 1'b0, 12'h003);
      @(negedge clk);
      check("abort ready rise", 32'(ready), 32'(1));
      for (int b = 0; b < 8; b++) begin
         valid = 1'b1;
         wrD   = 1'b1;
         @(negedge clk);
      end
      valid = 1'b0;
      wrD   = 1'b0;
      rst   = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort ready after rst", 32'(ready), 32'(0));
      do_read(1'b0, 12'h003, 1, "after_abort");

      for (int it = 0; it < 8; it++) begin
         rid    = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b01;
         raddr  = 12'($urandom_range(16, 4000));
         rn     = int'($urandom_range(1, 3));
         rburst = (rn > 1) ? 1'b1 : 1'($urandom_range(0, 1));
         for (int w = 0; w < 4; w++) wbuf[w] = 16'($urandom);
         do_write(rid, rburst, raddr, rn, int'($urandom_range(0, rn * DW)),
                  $sformatf("rnd%0d", it));
         if (rid == 2'b01) do_read(rburst, raddr, rn, $sformatf("rnd%0d", it));
         else              do_read(1'b0, 12'h000, 1, $sformatf("rnd%0d_addr0", it));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
